// File: rtl/ifid_skid.sv
// IF->ID pipeline register with valid/ready handshake, optional 1-entry skid buffer,
// synchronous flush, NOP insertion on bubbles and a saturating bubble counter.
module ifid_skid #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        INST_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'hBFC0_0000,
  parameter logic [INST_W-1:0]  NOP_INST = 32'h0000_0000,
  parameter bit                 SKID     = 1'b1,
  parameter int unsigned        CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  input  logic              flush,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              skid_valid;
  logic [ADDR_W-1:0] skid_pc;
  logic [INST_W-1:0] skid_inst;
  logic              ready_q;

  logic              in_fire, out_fire;
  logic              n_id_valid, n_skid_valid;
  logic [ADDR_W-1:0] n_id_pc, n_skid_pc;
  logic [INST_W-1:0] n_id_inst, n_skid_inst;

  // In skid mode if_ready comes from a register (no path from id_ready); rst only gates it.
  assign if_ready = SKID ? (ready_q & ~rst) : (~rst & (id_ready | ~id_valid));
  assign in_fire  = if_valid & if_ready;
  assign out_fire = id_valid & id_ready;

  always_comb begin
    n_id_valid   = id_valid;
    n_id_pc      = id_pc;
    n_id_inst    = id_inst;
    n_skid_valid = skid_valid;
    n_skid_pc    = skid_pc;
    n_skid_inst  = skid_inst;
    if (flush) begin
      n_id_valid   = 1'b0;
      n_skid_valid = 1'b0;
      n_id_inst    = NOP_INST;
    end else if (!id_valid || out_fire) begin
      if (SKID && skid_valid) begin
        n_id_valid   = 1'b1;
        n_id_pc      = skid_pc;
        n_id_inst    = skid_inst;
        n_skid_valid = 1'b0;
        if (in_fire) begin
          n_skid_valid = 1'b1;
          n_skid_pc    = if_pc;
          n_skid_inst  = if_inst;
        end
      end else if (in_fire) begin
        n_id_valid = 1'b1;
        n_id_pc    = if_pc;
        n_id_inst  = if_inst;
      end else begin
        n_id_valid = 1'b0;
        n_id_inst  = NOP_INST;
      end
    end else if (SKID && in_fire) begin
      n_skid_valid = 1'b1;
      n_skid_pc    = if_pc;
      n_skid_inst  = if_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid   <= 1'b0;
      id_pc      <= RESET_PC;
      id_inst    <= NOP_INST;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_inst  <= '0;
      ready_q    <= 1'b1;
      bubble_cnt <= '0;
    end else begin
      id_valid   <= n_id_valid;
      id_pc      <= n_id_pc;
      id_inst    <= n_id_inst;
      skid_valid <= n_skid_valid;
      skid_pc    <= n_skid_pc;
      skid_inst  <= n_skid_inst;
      ready_q    <= ~n_skid_valid;
      if (!id_valid && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ifid_skid.sv
// Bench for ifid_skid: a SKID=1 instance and a SKID=0/CNT_W=4 instance share stimulus and
// are compared against a queue-style occupancy model per instance.
module tb_ifid_skid;
  logic        clk = 1'b0;
  logic        rst, if_valid, flush, id_ready;
  logic [31:0] if_pc, if_inst;

  logic        rdy1, vld1, rdy0, vld0;
  logic [31:0] pc1, inst1, pc0, inst0;
  logic [15:0] bc1;
  logic [3:0]  bc0;

  int unsigned checks = 0, errors = 0;

  // model state per instance: index 0 = SKID=0, 1 = SKID=1
  int unsigned sz [2];
  logic [63:0] ent [2][2];
  logic [31:0] lastpc [2];
  int unsigned bcnt [2];
  int unsigned bmax [2];

  always #5 clk = ~clk;

  ifid_skid #(.SKID(1'b1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(rdy1), .if_pc(if_pc),
    .if_inst(if_inst), .flush(flush), .id_valid(vld1), .id_ready(id_ready),
    .id_pc(pc1), .id_inst(inst1), .bubble_cnt(bc1));

  ifid_skid #(.SKID(1'b0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(rdy0), .if_pc(if_pc),
    .if_inst(if_inst), .flush(flush), .id_valid(vld0), .id_ready(id_ready),
    .id_pc(pc0), .id_inst(inst0), .bubble_cnt(bc0));

  task automatic chk(input string tag, input int m, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[skid=%0d] observed %h expected %h", tag, m, obs, exp);
    end
  endtask

  function automatic bit model_ready(int m);
    if (rst) return 1'b0;
    if (m == 1) return sz[1] < 2;
    return (sz[0] == 0) || id_ready;
  endfunction

  task automatic model_edge(int m);
    bit rdy, inf, outf;
    if (rst) begin
      sz[m] = 0; lastpc[m] = 32'hBFC0_0000; bcnt[m] = 0;
      return;
    end
    if (sz[m] == 0 && bcnt[m] < bmax[m]) bcnt[m]++;
    rdy  = model_ready(m);
    inf  = if_valid && rdy;
    outf = (sz[m] > 0) && id_ready;
    if (outf) begin ent[m][0] = ent[m][1]; sz[m]--; end
    if (inf) begin ent[m][sz[m]] = {if_pc, if_inst}; sz[m]++; end
    if (flush) sz[m] = 0;
    if (sz[m] > 0) lastpc[m] = ent[m][0][63:32];
  endtask

  task automatic check_outputs(int m);
    logic [63:0] head;
    head = ent[m][0];
    chk("id_valid", m, m ? 64'(vld1) : 64'(vld0), 64'(sz[m] > 0));
    chk("id_pc", m, m ? 64'(pc1) : 64'(pc0), 64'(sz[m] > 0 ? head[63:32] : lastpc[m]));
    chk("id_inst", m, m ? 64'(inst1) : 64'(inst0), 64'(sz[m] > 0 ? head[31:0] : 32'h0));
    chk("bubble_cnt", m, m ? 64'(bc1) : 64'(bc0), 64'(bcnt[m]));
  endtask

  // inputs are already set; check ready, clock, update model, check registered outputs
  task automatic step();
    #1;
    chk("if_ready", 0, 64'(rdy0), 64'(model_ready(0)));
    chk("if_ready", 1, 64'(rdy1), 64'(model_ready(1)));
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_outputs(0);
    check_outputs(1);
  endtask

  task automatic drive(input logic r, input logic v, input logic [31:0] pc,
                       input logic f, input logic dr);
    rst = r; if_valid = v; if_pc = pc; if_inst = ~pc ^ 32'h1357_9BDF; flush = f; id_ready = dr;
  endtask

  initial begin
    bmax[0] = 15; bmax[1] = 65535;
    sz[0] = 0; sz[1] = 0; bcnt[0] = 0; bcnt[1] = 0;
    lastpc[0] = 32'hBFC0_0000; lastpc[1] = 32'hBFC0_0000;
    @(negedge clk);

    // reset held for two cycles
    drive(1, 0, 32'h0, 0, 1); step(); step();
    chk("rst_pc", 1, 64'(pc1), 64'h0000_0000_BFC0_0000);
    chk("rst_inst", 0, 64'(inst0), 64'h0);
    chk("rst_ready", 1, 64'(rdy1), 64'h0);

    // idle after reset: bubble counter climbs and saturates on the 4-bit instance
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 32'h0, 0, 1); step();
    end
    chk("bubble_sat", 0, 64'(bc0), 64'd15);
    chk("bubble_20", 1, 64'(bc1), 64'd20);

    // back-to-back stream
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 32'(i * 4), 0, 1); step();
    end

    // backpressure: 0x10 in main, 0x14 into skid
    drive(0, 1, 32'h10, 0, 1); step();
    drive(0, 1, 32'h14, 0, 0); step();
    drive(0, 1, 32'h18, 0, 0); step();
    chk("stall_ready", 1, 64'(rdy1), 64'h0);
    chk("stall_pc", 1, 64'(pc1), 64'h10);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 32'h0, 0, 1); step();
    end

    // flush with main and skid full, then resume
    drive(0, 1, 32'h30, 0, 0); step();
    drive(0, 1, 32'h34, 0, 0); step();
    drive(0, 1, 32'h40, 1, 0); step();
    chk("flush_valid", 1, 64'(vld1), 64'h0);
    drive(0, 1, 32'h80, 0, 1); step();
    chk("post_flush_pc", 1, 64'(pc1), 64'h80);
    drive(0, 0, 32'h0, 0, 1); step();

    // reset mid-stall
    drive(0, 1, 32'h100, 0, 0); step();
    drive(0, 1, 32'h104, 0, 0); step();
    drive(1, 1, 32'h108, 0, 0); step();
    drive(0, 0, 32'h0, 0, 1); step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), $urandom,
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
